// File: rtl/rf_write_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : rf_write_scheduler
//  Description : Round-robin arbiter for the register-file write port, with a
//                hardware clear sequencer that zeroes registers 1..2**ADDR-1.
//                All register-file write controls come straight from flops.
//  Revision    : 1.0 - initial release
// ============================================================================
module rf_write_scheduler #(
    parameter int N    = 32,
    parameter int ADDR = 5
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req0_valid_i,
    output logic            req0_ready_o,
    input  logic [ADDR-1:0] req0_addr_i,
    input  logic [N-1:0]    req0_data_i,
    input  logic            req1_valid_i,
    output logic            req1_ready_o,
    input  logic [ADDR-1:0] req1_addr_i,
    input  logic [N-1:0]    req1_data_i,
    input  logic            clear_i,
    output logic            clear_busy_o,
    output logic            Reg_Write_o,
    output logic [ADDR-1:0] Write_Register_o,
    output logic [N-1:0]    Write_Data_o
);

    typedef enum logic [0:0] {
        ST_ARB   = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    // Counter is one bit wider than the address so the walk never wraps.
    localparam logic [ADDR:0]   c_cnt_start  = (ADDR+1)'(2);
    localparam logic [ADDR:0]   c_cnt_one    = (ADDR+1)'(1);
    localparam logic [ADDR-1:0] c_first_addr = ADDR'(1);
    localparam logic [ADDR-1:0] c_last_addr  = '1;

    state_t          state_q, state_d;
    logic            ptr_q, ptr_d;       // 0: requester 0 wins a tie
    logic [ADDR:0]   cnt_q, cnt_d;
    logic            rw_q, rw_d;
    logic [ADDR-1:0] wa_q, wa_d;
    logic [N-1:0]    wd_q, wd_d;
    logic            busy_q, busy_d;
    logic            w_grant0;
    logic            w_grant1;

    // Next-state, arbitration and output-register load selection.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        cnt_d    = cnt_q;
        rw_d     = 1'b0;
        wa_d     = wa_q;
        wd_d     = wd_q;
        w_grant0 = 1'b0;
        w_grant1 = 1'b0;
        case (state_q)
            ST_ARB: begin
                if (clear_i) begin
                    // Clear wins over any pending request this cycle.
                    state_d = ST_CLEAR;
                    rw_d    = 1'b1;
                    wa_d    = c_first_addr;
                    wd_d    = '0;
                    cnt_d   = c_cnt_start;
                end else begin
                    w_grant0 = req0_valid_i && (!req1_valid_i || !ptr_q);
                    w_grant1 = req1_valid_i && (!req0_valid_i ||  ptr_q);
                    if (w_grant0) begin
                        rw_d  = |req0_addr_i;   // register 0 is hardwired zero
                        wa_d  = req0_addr_i;
                        wd_d  = req0_data_i;
                        ptr_d = 1'b1;
                    end else if (w_grant1) begin
                        rw_d  = |req1_addr_i;
                        wa_d  = req1_addr_i;
                        wd_d  = req1_data_i;
                        ptr_d = 1'b0;
                    end
                end
            end
            ST_CLEAR: begin
                if (wa_q == c_last_addr) begin
                    state_d = ST_ARB;
                end else begin
                    rw_d  = 1'b1;
                    wa_d  = cnt_q[ADDR-1:0];
                    wd_d  = '0;
                    cnt_d = cnt_q + c_cnt_one;
                end
            end
            default: state_d = ST_ARB;
        endcase
        busy_d = (state_d == ST_CLEAR);
    end

    // State, pointer, counter and registered register-file controls.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_ARB;
            ptr_q   <= 1'b0;
            cnt_q   <= '0;
            rw_q    <= 1'b0;
            wa_q    <= '0;
            wd_q    <= '0;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
            rw_q    <= rw_d;
            wa_q    <= wa_d;
            wd_q    <= wd_d;
            busy_q  <= busy_d;
        end
    end

    // Grants are only meaningful while out of reset.
    assign req0_ready_o     = w_grant0 && !reset;
    assign req1_ready_o     = w_grant1 && !reset;
    assign clear_busy_o     = busy_q;
    assign Reg_Write_o      = rw_q;
    assign Write_Register_o = wa_q;
    assign Write_Data_o     = wd_q;

endmodule
`default_nettype wire

// File: doc/rf_write_scheduler.md
# rf_write_scheduler

Arbitrates the single write port of the register file between two writeback requesters using round-robin valid/ready handshakes. It also sequences a hardware clear that walks registers 1..2**ADDR-1 and writes zero to each. It sits directly in front of the register file's Reg_Write_i / Write_Register_i / Write_Data_i inputs, and all three of those are driven from registered outputs of this block.

## Interface
- N, 32, data word width
- ADDR, 5, register address width (2**ADDR registers)

Clocking: one clock; reset is asynchronous and active-high.

- clk  in  1  clock, rising-edge
- reset  in  1  asynchronous, active-high reset
- req0_valid_i  in  1  requester 0 has a write pending
- req0_ready_o  out  1  requester 0 accepted this cycle
- req0_addr_i  in  ADDR  requester 0 destination register
- req0_data_i  in  N  requester 0 write data
- req1_valid_i, req1_ready_o, req1_addr_i, req1_data_i: same as requester 0, for requester 1
- clear_i  in  1  request a full register-file clear
- clear_busy_o  out  1  clear sequence in progress
- Reg_Write_o  out  1  write enable to the register file
- Write_Register_o  out  ADDR  write address to the register file
- Write_Data_o  out  N  write data to the register file

## Operation
- The state machine has two states: ARB and CLEAR.
- Reset state: ARB, priority pointer = requester 0, clear counter = 0.
- Reset values: Reg_Write_o = 0, Write_Register_o = 0, Write_Data_o = 0, clear_busy_o = 0, both ready = 0.
- Ready outputs (ARB only):
  - readyX_o is combinational from the valid inputs, clear_i and state.
  - Requesters must not make valid depend on ready.
  - At most one ready is high per cycle.
  - A transfer occurs when valid & ready are both high at a rising edge.
- Arbitration in ARB with clear_i = 0:
  - Only one valid: that requester gets ready.
  - Both valid: the requester named by the pointer gets ready.
  - After any grant, the pointer moves to the other requester.
  - With no grant, the pointer holds.
- Accepted transfer: the output register loads Write_Register_o = addr and Write_Data_o = data. Reg_Write_o = 1 unless addr = 0. Register 0 is hardwired zero, so an addr-0 write is acknowledged and dropped.
- No transfer in ARB: Reg_Write_o loads 0. Write_Register_o and Write_Data_o hold their previous values.
- clear_i high in ARB:
  - Both ready are forced low that cycle.
  - Next edge: state -> CLEAR, output register loads (Reg_Write_o = 1, addr 1, data 0), counter -> 2.
- CLEAR state:
  - Each edge loads (1, counter, 0) and increments the counter.
  - On the edge where the output holds address 2**ADDR-1, state -> ARB and Reg_Write_o loads 0.
  - Both ready are low throughout CLEAR.
  - clear_i is ignored in CLEAR.
  - The pointer is unchanged by a clear.
- clear_busy_o = (state == CLEAR), registered.
- The counter is ADDR+1 bits wide so the terminal compare cannot wrap.

## Timing
- Write latency: a transfer at edge E appears on the outputs after E. The register file captures it at E+1, so the data is readable asynchronously after E+1.
- Throughput: one accepted write per cycle, sustained.
- Clear:
  - clear_i sampled at E0.
  - Reg_Write_o is high for exactly 2**ADDR-1 consecutive cycles (31 by default), addresses 1..31 in order.
  - clear_busy_o is high in exactly those cycles.
  - The first new transfer can be accepted in the cycle after the address-31 write.
- Simultaneous clear_i and valid in ARB: clear wins, and no requester is acknowledged that cycle.
- Reset asserted mid-clear: the clear aborts immediately. Outputs go to reset values asynchronously, and partially cleared registers are not restored.
- Reset asserted mid-transfer: the pending output write is lost, because Reg_Write_o drops asynchronously.
- No combinational path exists from any input to Reg_Write_o, Write_Register_o or Write_Data_o.

## Test plan
- Single requester: req0 writes addr 5, data 0xDEADBEEF.
  - req0_ready_o = 1 in the same cycle.
  - Next cycle: Reg_Write_o = 1, Write_Register_o = 5.
  - Register 5 reads 0xDEADBEEF after the following edge.
- Contention: both valid continuously for 4 cycles, req0 to addr 1..4, req1 to addr 11..14, pointer starting at 0.
  - Grants alternate 0,1,0,1.
  - Outputs show addresses 1, 11, 2, 12.
- Register-0 drop: req1 writes addr 0, data 0xFFFFFFFF.
  - req1_ready_o = 1.
  - Reg_Write_o stays 0.
  - Register 0 reads 0.
- Full clear: fill registers 1..31 with random data, then pulse clear_i for 1 cycle while req0_valid_i = 1.
  - req0_ready_o = 0 for 32 cycles.
  - clear_busy_o is high for 31 cycles.
  - All registers read 0 afterwards.
  - req0 is accepted in the next cycle.
- Reset mid-clear: assert reset at the 10th clear write.
  - clear_busy_o and Reg_Write_o drop immediately, and state is ARB.
  - Registers 1..9 read 0; registers 10..31 keep their prior data.
- Back-to-back single writer: req1 valid for 8 cycles, addr 20..27.
  - 8 consecutive Reg_Write_o pulses.
  - Each register matches its data.
